// File: rtl/ahb_apb_bridge_n.sv
// rtl/ahb_apb_bridge_n.sv - AHB-Lite to APB3/APB4 bridge with NUM_SLAVES slots and error forwarding
// Optional PREADY watchdog is built only when APB_BRIDGE_TIMEOUT_EN is defined.
module ahb_apb_bridge_n #(
    parameter int NUM_SLAVES     = 8,
    parameter int SLOT_AW        = 12,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     HSEL,
    input  logic [ADDR_WIDTH-1:0]    HADDR,
    input  logic [1:0]               HTRANS,
    input  logic [2:0]               HSIZE,
    input  logic                     HWRITE,
    input  logic [6:0]               HPROT,
    input  logic                     HNONSEC,
    input  logic                     HREADY,
    input  logic [31:0]              HWDATA,
    output logic                     HREADYOUT,
    output logic [31:0]              HRDATA,
    output logic                     HRESP,
    output logic [SLOT_AW-1:0]       PADDR,
    output logic [NUM_SLAVES-1:0]    PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [2:0]               PPROT,
    output logic [3:0]               PSTRB,
    output logic [31:0]              PWDATA,
    input  logic [NUM_SLAVES*32-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]    PREADY,
    input  logic [NUM_SLAVES-1:0]    PSLVERR
);
    localparam int SLOT_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [SLOT_BITS:0] SLOT_LIMIT = (SLOT_BITS + 1)'(NUM_SLAVES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WCAP,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                state;
    logic [SLOT_BITS-1:0]  h_slot;
    logic                  h_slot_valid;
    logic [NUM_SLAVES-1:0] h_onehot;
    logic [3:0]            h_strb;
    logic [NUM_SLAVES-1:0] sel_q;
    logic                  slot_valid_q;
    logic [NUM_SLAVES-1:0] psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [SLOT_AW-1:0]    paddr_q;
    logic [2:0]            pprot_q;
    logic [3:0]            pstrb_q;
    logic [31:0]           pwdata_q;
    logic                  pready_sel;
    logic                  pslverr_sel;
    logic [31:0]           prdata_sel;
    logic                  timed_out;
    logic                  access_ok;
    logic                  accept;
    logic                  unused_inputs;

    assign unused_inputs = ^{HADDR, HPROT, HTRANS[0]};

    generate
        if (NUM_SLAVES > 1) begin : g_slot
            assign h_slot = HADDR[SLOT_AW +: SLOT_BITS];
        end else begin : g_single
            assign h_slot = '0;
        end
    endgenerate

    assign h_slot_valid = ({1'b0, h_slot} < SLOT_LIMIT);

    always_comb begin
        h_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            h_onehot[i] = (h_slot == SLOT_BITS'(i));
        end
    end

    always_comb begin
        h_strb = 4'b0000;
        if (HWRITE) begin
            case (HSIZE)
                3'd0:    h_strb = 4'b0001 << HADDR[1:0];
                3'd1:    h_strb = 4'b0011 << {HADDR[1], 1'b0};
                default: h_strb = 4'b1111;
            endcase
        end
    end

    // Slot response mux is an AND-OR over the captured one-hot select
    always_comb begin
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        prdata_sel  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            pready_sel  = pready_sel | (sel_q[i] & PREADY[i]);
            pslverr_sel = pslverr_sel | (sel_q[i] & PSLVERR[i]);
            prdata_sel  = prdata_sel | ({32{sel_q[i]}} & PRDATA[32*i +: 32]);
        end
    end

`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);

    logic [TO_W-1:0] to_cnt;
    logic            to_last;

    // PSEL is withdrawn on the edge the count reaches the limit, so the abort cycle shows it low
    assign timed_out = TO_EN && (to_cnt == TO_LIMIT);
    assign to_last   = TO_EN && (to_cnt == TO_LAST);
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timed_out = 1'b0;
`endif

    assign access_ok = (state == S_ACCESS) && !timed_out && pready_sel && !pslverr_sel;
    assign accept    = HSEL && HREADY && HTRANS[1] &&
                       ((state == S_IDLE) || (state == S_ERR2) || access_ok);

    always_comb begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b0;
        HRDATA    = '0;
        case (state)
            S_IDLE: HREADYOUT = 1'b1;
            S_ACCESS: begin
                HREADYOUT = access_ok;
                HRESP     = timed_out || (pready_sel && pslverr_sel);
                if (access_ok && !pwrite_q) begin
                    HRDATA = prdata_sel;
                end
            end
            S_ERR1: HRESP = 1'b1;
            S_ERR2: begin
                HREADYOUT = 1'b1;
                HRESP     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state        <= S_IDLE;
            sel_q        <= '0;
            slot_valid_q <= 1'b0;
            psel_q       <= '0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pprot_q      <= '0;
            pstrb_q      <= '0;
            pwdata_q     <= '0;
`ifdef APB_BRIDGE_TIMEOUT_EN
            to_cnt       <= '0;
`endif
        end else begin
            if (accept) begin
                sel_q        <= h_onehot;
                slot_valid_q <= h_slot_valid;
                pwrite_q     <= HWRITE;
                paddr_q      <= {HADDR[SLOT_AW-1:2], 2'b00};
                pprot_q      <= {~HPROT[0], HNONSEC, HPROT[1]};
                pstrb_q      <= h_strb;
            end
            case (state)
                S_IDLE: begin
                    if (accept) state <= S_WCAP;
                end
                S_WCAP: begin
                    pwdata_q <= HWDATA;
`ifdef APB_BRIDGE_TIMEOUT_EN
                    to_cnt   <= '0;
`endif
                    if (slot_valid_q) begin
                        psel_q <= sel_q;
                        state  <= S_SETUP;
                    end else begin
                        state  <= S_ERR1;
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state     <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (timed_out) begin
                        state <= S_ERR2;
                    end else if (pready_sel) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        if (pslverr_sel)  state <= S_ERR2;
                        else if (accept)  state <= S_WCAP;
                        else              state <= S_IDLE;
                    end else begin
`ifdef APB_BRIDGE_TIMEOUT_EN
                        to_cnt <= to_cnt + TO_W'(1);
                        if (to_last) begin
                            psel_q    <= '0;
                            penable_q <= 1'b0;
                        end
`endif
                    end
                end
                S_ERR1: state <= S_ERR2;
                S_ERR2: state <= accept ? S_WCAP : S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PPROT   = pprot_q;
    assign PSTRB   = pstrb_q;
    assign PWDATA  = pwdata_q;

endmodule
